// File: rtl/debouncer_pkg.sv
// Shared types for the button front-end: debouncer and press classifier.
package debouncer_pkg;

  // Gesture classifier states; IDLE is the only non-busy state.
  typedef enum logic [2:0] {
    IDLE,
    PRESSED,
    LONG_HELD,
    WAIT_GAP,
    SECOND
  } press_state_e;

  // Larger of two cycle counts, used to size the shared gesture timer.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/press_timer.sv
// Saturating up-counter timing the current gesture phase.
// A clear wins over an enable, and the count sticks at all-ones so that a
// long idle phase can never wrap back onto a terminal count.
module press_timer #(
  parameter int Width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [Width-1:0] cnt_o
);

  // Count enabled cycles, restarting on clear and saturating at the top.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_o <= '0;
    end else if (clear_i) begin
      cnt_o <= '0;
    end else if (en_i && (cnt_o != '1)) begin
      cnt_o <= cnt_o + 1'b1;
    end
  end

endmodule

// File: rtl/press_classifier.sv
// Classifies debounced button gestures into short press, long press and
// double click, emitting one registered single-cycle tick per gesture.
module press_classifier
  import debouncer_pkg::*;
#(
  parameter int LongCycles = 100_000_000,
  parameter int GapCycles  = 25_000_000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic db_level_i,
  output logic short_tick_o,
  output logic long_tick_o,
  output logic double_tick_o,
  output logic busy_o
);

  localparam int TimerWidth = $clog2(max_int(LongCycles, GapCycles));
  localparam logic [TimerWidth-1:0] LongLast = TimerWidth'(LongCycles - 1);
  localparam logic [TimerWidth-1:0] GapLast  = TimerWidth'(GapCycles - 1);

  press_state_e          state;
  logic                  level_q;
  logic                  rise;
  logic                  fall_unused_guard;
  logic                  state_change;
  logic                  timer_en;
  logic [TimerWidth-1:0] timer;

  // Previous level; resets high so a button held through reset needs a
  // fresh release-and-press before it is seen as a gesture.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      level_q <= 1'b1;
    end else begin
      level_q <= db_level_i;
    end
  end

  assign rise              = db_level_i & ~level_q;
  assign fall_unused_guard = 1'b0;

  // Flags the cycles on which the FSM will leave its current state, so the
  // timer restarts from zero in every new state.
  always_comb begin
    state_change = 1'b0;
    case (state)
      IDLE:      state_change = rise;
      PRESSED:   state_change = ~db_level_i | (timer == LongLast);
      LONG_HELD: state_change = ~db_level_i;
      WAIT_GAP:  state_change = rise | (timer == GapLast);
      SECOND:    state_change = ~db_level_i;
      default:   state_change = 1'b1;
    endcase
  end

  assign timer_en = ((state == PRESSED) || (state == WAIT_GAP)) & ~fall_unused_guard;

  press_timer #(
    .Width (TimerWidth)
  ) u_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear_i (state_change),
    .en_i    (timer_en),
    .cnt_o   (timer)
  );

  // Gesture FSM with registered ticks; a release or re-press beats a
  // terminal count that lands on the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state         <= IDLE;
      short_tick_o  <= 1'b0;
      long_tick_o   <= 1'b0;
      double_tick_o <= 1'b0;
    end else begin
      short_tick_o  <= 1'b0;
      long_tick_o   <= 1'b0;
      double_tick_o <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            state <= PRESSED;
          end
        end
        PRESSED: begin
          if (!db_level_i) begin
            state <= WAIT_GAP;
          end else if (timer == LongLast) begin
            state       <= LONG_HELD;
            long_tick_o <= 1'b1;
          end
        end
        LONG_HELD: begin
          if (!db_level_i) begin
            state <= IDLE;
          end
        end
        WAIT_GAP: begin
          if (rise) begin
            state <= SECOND;
          end else if (timer == GapLast) begin
            state        <= IDLE;
            short_tick_o <= 1'b1;
          end
        end
        SECOND: begin
          if (!db_level_i) begin
            state         <= IDLE;
            double_tick_o <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign busy_o = (state != IDLE);

endmodule

// File: tb/tb_press_classifier.sv
// Self-checking bench for press_classifier: level traces are built as
// run-length segments, driven one value per cycle, and the observed ticks
// and busy flag are compared against a run-length gesture model.
module tb_press_classifier;

  localparam int LONG = 20;
  localparam int GAP  = 10;
  localparam int MAXN = 1024;

  logic clk_i      = 1'b0;
  logic rst_i      = 1'b1;
  logic db_level_i = 1'b0;
  logic short_tick_o;
  logic long_tick_o;
  logic double_tick_o;
  logic busy_o;

  int checks = 0;
  int errors = 0;

  bit lv    [MAXN];
  int n;
  bit obs_s [MAXN];
  bit obs_l [MAXN];
  bit obs_d [MAXN];
  bit obs_b [MAXN];
  bit exp_s [MAXN];
  bit exp_l [MAXN];
  bit exp_d [MAXN];
  bit exp_b [MAXN];

  press_classifier #(
    .LongCycles (LONG),
    .GapCycles  (GAP)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .db_level_i    (db_level_i),
    .short_tick_o  (short_tick_o),
    .long_tick_o   (long_tick_o),
    .double_tick_o (double_tick_o),
    .busy_o        (busy_o)
  );

  // Free-running 100 MHz clock.
  always #5 clk_i = ~clk_i;

  task automatic clear_trace();
    n = 0;
  endtask

  task automatic push_seg(input bit val, input int len);
    for (int i = 0; i < len; i++) begin
      if (n < MAXN) begin
        lv[n] = val;
        n++;
      end
    end
  endtask

  task automatic do_reset(input bit lvl);
    rst_i      = 1'b1;
    db_level_i = lvl;
    repeat (3) @(posedge clk_i);
    #1;
  endtask

  function automatic bit is_rise(input int t);
    if (t == 0) return 1'b0;
    return lv[t] && !lv[t-1];
  endfunction

  task automatic mark_busy(input int from, input int to);
    for (int i = from; i <= to; i++) begin
      if (i >= 0 && i < n) exp_b[i] = 1'b1;
    end
  endtask

  // Gesture model over the whole trace: walk rises, measure the high run and
  // the following low run, and place each tick by the stated latencies.
  task automatic build_expected();
    int t, r, f, s, e;
    for (int i = 0; i < n; i++) begin
      exp_s[i] = 0; exp_l[i] = 0; exp_d[i] = 0; exp_b[i] = 0;
    end
    t = 0;
    while (t < n) begin
      if (!is_rise(t)) begin
        t++;
        continue;
      end
      r = t;
      f = r;
      while (f < n && lv[f]) f++;
      if (f - r >= LONG + 1) begin
        if (r + LONG + 1 < n) exp_l[r + LONG + 1] = 1'b1;
        mark_busy(r + 1, (f < n) ? f : n - 1);
        t = f;
        continue;
      end
      if (f >= n) begin
        mark_busy(r + 1, n - 1);
        break;
      end
      s = f;
      while (s < n && !lv[s]) s++;
      if (s < n && (s - f) <= GAP) begin
        e = s;
        while (e < n && lv[e]) e++;
        mark_busy(r + 1, (e < n) ? e : n - 1);
        if (e + 1 < n) exp_d[e + 1] = 1'b1;
        t = e;
      end else begin
        mark_busy(r + 1, f + GAP);
        if (f + GAP + 1 < n) exp_s[f + GAP + 1] = 1'b1;
        t = f + GAP + 1;
      end
    end
  endtask

  // Releases reset (which must already be asserted), drives the trace and
  // compares every cycle against the model.
  task automatic run_trace(input string name);
    @(posedge clk_i);
    #1;
    db_level_i = lv[0];
    rst_i      = 1'b0;
    for (int t = 0; t < n; t++) begin
      if (t > 0) begin
        @(posedge clk_i);
        #1;
        db_level_i = lv[t];
      end
      @(negedge clk_i);
      obs_s[t] = short_tick_o;
      obs_l[t] = long_tick_o;
      obs_d[t] = double_tick_o;
      obs_b[t] = busy_o;
    end
    build_expected();
    for (int t = 0; t < n; t++) begin
      checks++;
      if (obs_s[t] !== exp_s[t]) begin
        errors++;
        $display("[TB] FAIL %s short_tick cycle %0d: got %0b expected %0b", name, t, obs_s[t], exp_s[t]);
      end
      checks++;
      if (obs_l[t] !== exp_l[t]) begin
        errors++;
        $display("[TB] FAIL %s long_tick cycle %0d: got %0b expected %0b", name, t, obs_l[t], exp_l[t]);
      end
      checks++;
      if (obs_d[t] !== exp_d[t]) begin
        errors++;
        $display("[TB] FAIL %s double_tick cycle %0d: got %0b expected %0b", name, t, obs_d[t], exp_d[t]);
      end
      checks++;
      if (obs_b[t] !== exp_b[t]) begin
        errors++;
        $display("[TB] FAIL %s busy cycle %0d: got %0b expected %0b", name, t, obs_b[t], exp_b[t]);
      end
    end
  endtask

  function automatic int first_obs(input int kind);
    for (int t = 0; t < n; t++) begin
      if (kind == 0 && obs_s[t]) return t;
      if (kind == 1 && obs_l[t]) return t;
      if (kind == 2 && obs_d[t]) return t;
    end
    return -1;
  endfunction

  function automatic int tick_count();
    int c = 0;
    for (int t = 0; t < n; t++) c += int'(obs_s[t]) + int'(obs_l[t]) + int'(obs_d[t]);
    return c;
  endfunction

  task automatic test_reset();
    int got;
    rst_i      = 1'b1;
    db_level_i = 1'b0;
    #23;
    got = {short_tick_o, long_tick_o, double_tick_o, busy_o};
    checks++;
    if (got !== 0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %b expected 0000", got[3:0]);
    end
  endtask

  task automatic test_short();
    int got;
    do_reset(1'b0);
    clear_trace();
    push_seg(1'b0, 3); push_seg(1'b1, 5); push_seg(1'b0, 25);
    run_trace("short");
    got = first_obs(0);
    checks++;
    if (got !== 19) begin
      errors++;
      $display("[TB] FAIL short_latency: got cycle %0d expected 19", got);
    end
    got = tick_count();
    checks++;
    if (got !== 1) begin
      errors++;
      $display("[TB] FAIL short_single_tick: got %0d ticks expected 1", got);
    end
  endtask

  task automatic test_long();
    int got;
    do_reset(1'b0);
    clear_trace();
    push_seg(1'b0, 3); push_seg(1'b1, 40); push_seg(1'b0, 20);
    run_trace("long");
    got = first_obs(1);
    checks++;
    if (got !== 24) begin
      errors++;
      $display("[TB] FAIL long_latency: got cycle %0d expected 24", got);
    end
    checks++;
    if (obs_b[43] !== 1'b1 || obs_b[44] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL long_busy_release: got %0b%0b expected 10", obs_b[43], obs_b[44]);
    end
    got = tick_count();
    checks++;
    if (got !== 1) begin
      errors++;
      $display("[TB] FAIL long_single_tick: got %0d ticks expected 1", got);
    end
  endtask

  task automatic test_double();
    int got;
    do_reset(1'b0);
    clear_trace();
    push_seg(1'b0, 3); push_seg(1'b1, 4); push_seg(1'b0, 6);
    push_seg(1'b1, 4); push_seg(1'b0, 20);
    run_trace("double");
    got = first_obs(2);
    checks++;
    if (got !== 18) begin
      errors++;
      $display("[TB] FAIL double_latency: got cycle %0d expected 18", got);
    end
    got = first_obs(0);
    checks++;
    if (got !== -1) begin
      errors++;
      $display("[TB] FAIL double_no_short: got cycle %0d expected none (-1)", got);
    end
  endtask

  task automatic test_boundaries();
    int got;
    do_reset(1'b0);
    clear_trace();
    push_seg(1'b0, 3); push_seg(1'b1, 20); push_seg(1'b0, 30);
    run_trace("release_at_19");
    got = first_obs(0);
    checks++;
    if (got !== 34 || first_obs(1) !== -1) begin
      errors++;
      $display("[TB] FAIL release_at_19: got short %0d long %0d expected 34 -1", got, first_obs(1));
    end
    do_reset(1'b0);
    clear_trace();
    push_seg(1'b0, 3); push_seg(1'b1, 5); push_seg(1'b0, 10);
    push_seg(1'b1, 3); push_seg(1'b0, 20);
    run_trace("repress_at_9");
    got = first_obs(2);
    checks++;
    if (got !== 22 || first_obs(0) !== -1) begin
      errors++;
      $display("[TB] FAIL repress_at_9: got double %0d short %0d expected 22 -1", got, first_obs(0));
    end
    do_reset(1'b0);
    clear_trace();
    push_seg(1'b0, 3); push_seg(1'b1, 5); push_seg(1'b0, 11);
    push_seg(1'b1, 5); push_seg(1'b0, 25);
    run_trace("repress_at_11");
    got = first_obs(0);
    checks++;
    if (got !== 19 || obs_b[20] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL repress_at_11: got short %0d busy %0b expected 19 1", got, obs_b[20]);
    end
  endtask

  task automatic test_held_through_reset();
    int got;
    do_reset(1'b1);
    clear_trace();
    push_seg(1'b1, 8); push_seg(1'b0, 5); push_seg(1'b1, 5); push_seg(1'b0, 25);
    run_trace("held_reset");
    got = first_obs(0);
    checks++;
    if (got !== 29) begin
      errors++;
      $display("[TB] FAIL held_reset_first_tick: got cycle %0d expected 29", got);
    end
  endtask

  task automatic test_reset_mid();
    int got;
    do_reset(1'b0);
    clear_trace();
    push_seg(1'b0, 2); push_seg(1'b1, 11);
    run_trace("mid_pre");
    checks++;
    if (busy_o !== 1'b1) begin
      errors++;
      $display("[TB] FAIL mid_busy_before_reset: got %0b expected 1", busy_o);
    end
    #2;
    rst_i = 1'b1;
    #1;
    got = {short_tick_o, long_tick_o, double_tick_o, busy_o};
    checks++;
    if (got !== 0) begin
      errors++;
      $display("[TB] FAIL mid_reset_outputs: got %b expected 0000", got[3:0]);
    end
    repeat (2) @(posedge clk_i);
    clear_trace();
    push_seg(1'b1, 5); push_seg(1'b0, 40);
    run_trace("mid_post");
    got = tick_count();
    checks++;
    if (got !== 0) begin
      errors++;
      $display("[TB] FAIL mid_no_tick_after: got %0d ticks expected 0", got);
    end
  endtask

  function automatic int pick_high();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(LONG - 1, LONG + 1));
      1:       return int'($urandom_range(1, 8));
      2:       return int'($urandom_range(10, 30));
      default: return LONG;
    endcase
  endfunction

  function automatic int pick_low();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(GAP - 1, GAP + 1));
      1:       return int'($urandom_range(1, 8));
      2:       return int'($urandom_range(12, 15));
      default: return GAP;
    endcase
  endfunction

  task automatic test_random();
    for (int k = 0; k < 8; k++) begin
      do_reset(1'b0);
      clear_trace();
      push_seg(1'b0, int'($urandom_range(2, 5)));
      for (int g = 0; g < 8; g++) begin
        push_seg(1'b1, pick_high());
        push_seg(1'b0, pick_low());
      end
      push_seg(1'b0, 40);
      run_trace("random");
    end
  endtask

  // Scenario sequence.
  initial begin
    $display("[TB] press_classifier bench start");
    test_reset();
    test_short();
    test_long();
    test_double();
    test_boundaries();
    test_held_through_reset();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
